// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks an inclusive register index range through one
// combinational register-file read port and streams each captured word out
// over a valid/ready interface, tagged with its register index.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   start_i              one-cycle dump request, accepted only when idle
//   abort_i              cancels a dump in progress (no done pulse)
//   first_addr_i         first index of the range, sampled on start
//   last_addr_i          last index (inclusive), sampled on start
//   rd_addr_o            read address to the register file
//   rd_data_i            combinational read data for rd_addr_o
//   out_valid_o          out_data_o / out_index_o hold a word
//   out_ready_i          sink accepts the current word
//   out_data_o           captured register value
//   out_index_o          register index of out_data_o
//   busy_o               high whenever a dump is active
//   done_o               one-cycle pulse after the last word is accepted
module regfile_dump_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] first_addr_i,
  input  logic [ADDR_WIDTH-1:0] last_addr_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_index_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] idx_q,       idx_d;
  logic [ADDR_WIDTH-1:0] end_q,       end_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      end_q       <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      end_q       <= end_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // appear registered in the same cycle the state is entered.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    end_d       = end_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          idx_d   = first_addr_i;
          end_d   = last_addr_i;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Capture on this edge: a write landing on the same edge is not seen
        out_data_d  = rd_data_i;
        out_index_d = idx_q;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready_i) begin
          if (idx_q == end_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);  // wraps modulo NUM_REGS
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any handshake on the same edge
    if (abort_i && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
    end

    rd_addr_d   = ((state_d == S_READ) || (state_d == S_SEND)) ? idx_d : '0;
    out_valid_d = (state_d == S_SEND);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  assign rd_addr_o   = rd_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_index_o = out_index_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a small behavioural register
// file (write port updated on the rising edge, combinational read port).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_regfile_dump_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [AW-1:0] first_a, last_a;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          busy, done;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] regs [32];

  int tests = 0;
  int fails = 0;
  int q_idx [$];
  logic [DW-1:0] q_data [$];
  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;
  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .first_addr_i(first_a),
    .last_addr_i (last_a),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_index_o (out_index),
    .busy_o      (busy),
    .done_o      (done)
  );

  function automatic logic [DW-1:0] pat(input int n);
    return 32'(n * 32'h1111_1111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_dump(input int f, input int l);
    first_a = AW'(f);
    last_a  = AW'(l);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Records accepted words until done or the cycle budget runs out
  task automatic collect(input int budget);
    bit got_done = 1'b0;
    q_idx.delete();
    q_data.delete();
    cyc = 0;
    for (int c = 0; c < budget; c++) begin
      if (out_valid && out_ready) begin
        q_idx.push_back(int'(out_index));
        q_data.push_back(out_data);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("collect_done_seen", 32'(got_done), 32'd1);
  endtask

  initial begin
    int bad;
    int found;
    logic [DW-1:0] h_data;
    logic [AW-1:0] h_idx, h_addr;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; first_a = '0; last_a = '0;
    out_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Preload the register file while reset is held
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = (i == 5) ? 32'hDEAD_BEEF : pat(i);
      @(negedge clk);
    end
    wr_en = 1'b0;

    chk("rst_rd_addr",   32'(rd_addr),   32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word 5..5
    out_ready = 1'b1;
    start_dump(5, 5);
    chk("t1_busy_read",   32'(busy),      32'd1);
    chk("t1_rd_addr",     32'(rd_addr),   32'd5);
    chk("t1_valid_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid",       32'(out_valid), 32'd1);
    chk("t1_index",       32'(out_index), 32'd5);
    chk("t1_data",        out_data,       32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_done",        32'(done),      32'd1);
    chk("t1_valid_done",  32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_done_low",    32'(done),      32'd0);
    chk("t1_busy_low",    32'(busy),      32'd0);
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = pat(5);
    @(negedge clk);
    wr_en = 1'b0;

    // Full range 0..31
    start_dump(0, 31);
    collect(200);
    chk("t2_count",  32'(q_idx.size()), 32'd32);
    chk("t2_cycles", 32'(cyc),          32'd64);
    bad = 0;
    for (int i = 0; i < q_idx.size(); i++)
      if (q_idx[i] != i || q_data[i] !== pat(i)) bad++;
    chk("t2_order_data", 32'(bad), 32'd0);
    @(negedge clk);

    // Wrapping range 30..1
    start_dump(30, 1);
    collect(100);
    chk("t3_count", 32'(q_idx.size()), 32'd4);
    bad = 0;
    if (q_idx.size() == 4) begin
      if (q_idx[0] != 30 || q_idx[1] != 31 || q_idx[2] != 0 || q_idx[3] != 1) bad++;
      if (q_data[0] !== pat(30) || q_data[1] !== pat(31) ||
          q_data[2] !== pat(0)  || q_data[3] !== pat(1)) bad++;
    end
    chk("t3_wrap_seq", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid || busy) bad++;
    end
    chk("t3_no_extra", 32'(bad), 32'd0);

    // Backpressure: out_ready low for 10 cycles in SEND
    out_ready = 1'b0;
    start_dump(10, 10);
    @(negedge clk);
    chk("t4_valid",   32'(out_valid), 32'd1);
    chk("t4_data",    out_data,       32'hAAAA_AAAA);
    chk("t4_index",   32'(out_index), 32'd10);
    chk("t4_rd_addr", 32'(rd_addr),   32'd10);
    h_data = out_data; h_idx = out_index; h_addr = rd_addr;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== h_data || out_index !== h_idx || rd_addr !== h_addr) bad++;
    end
    chk("t4_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_done",       32'(done),      32'd1);
    chk("t4_valid_drop", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Start and abort together in IDLE
    abort = 1'b1;
    start_dump(0, 3);
    abort = 1'b0;
    chk("t5_start_abort_idle", 32'(busy), 32'd0);

    // Abort during SEND of index 7 with out_ready high
    start_dump(0, 31);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid && out_index == AW'(7)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("t5_reach_idx7", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_valid", 32'(out_valid), 32'd0);
    chk("t5_abort_busy",  32'(busy),      32'd0);
    chk("t5_abort_done",  32'(done),      32'd0);
    chk("t5_abort_addr",  32'(rd_addr),   32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || out_valid) bad++;
    end
    chk("t5_quiet", 32'(bad), 32'd0);
    start_dump(3, 4);
    collect(50);
    chk("t5_count", 32'(q_idx.size()), 32'd2);
    bad = 0;
    if (q_idx.size() == 2 && (q_idx[0] != 3 || q_idx[1] != 4)) bad++;
    chk("t5_indices", 32'(bad), 32'd0);
    @(negedge clk);

    // Write to r2 on the capture edge, later write, and start while busy
    out_ready = 1'b0;
    start_dump(2, 3);
    wr_en = 1'b1; wr_addr = AW'(2); wr_data = 32'h1234_5678;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t6_old_data", out_data,       32'h2222_2222);
    chk("t6_index",    32'(out_index), 32'd2);
    wr_en = 1'b1; wr_addr = AW'(2); wr_data = 32'hCAFE_F00D;
    start_dump(7, 9);
    wr_en = 1'b0;
    chk("t6_hold_after_write", out_data, 32'h2222_2222);
    out_ready = 1'b1;
    collect(50);
    chk("t6_count", 32'(q_idx.size()), 32'd2);
    bad = 0;
    if (q_idx.size() == 2) begin
      if (q_idx[0] != 2 || q_idx[1] != 3) bad++;
      if (q_data[0] !== 32'h2222_2222 || q_data[1] !== pat(3)) bad++;
    end
    chk("t6_ignore_start", 32'(bad), 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-dump
    start_dump(0, 31);
    repeat (5) @(negedge clk);
    chk("t7_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rd_addr",   32'(rd_addr),   32'd0);
    chk("t7_out_valid", 32'(out_valid), 32'd0);
    chk("t7_out_data",  out_data,       32'd0);
    chk("t7_out_index", 32'(out_index), 32'd0);
    chk("t7_busy",      32'(busy),      32'd0);
    chk("t7_done",      32'(done),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side initiator for the 32-entry register file.
- Walks a requested address range through one register-file read port and streams each word out on a valid/ready interface, tagged with its register index.
- Used by debug and trace logic to dump architectural state without stalling the write port.
- Sits between the register file's read port (read address out, read data in, combinational return) and a debug or trace sink.

Parameters:
DATA_WIDTH, 32, register word width; must match the register file data width
ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH

Ports:
clock  input  1  sole clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a dump; honoured only in IDLE
abort  input  1  cancels any dump in progress
first_addr  input  ADDR_WIDTH  first register index; sampled when start is accepted
last_addr  input  ADDR_WIDTH  last register index, inclusive; sampled when start is accepted
rd_addr  output  ADDR_WIDTH  read address driven to the register-file read port
rd_data  input  DATA_WIDTH  combinational read data returned for rd_addr
out_valid  output  1  out_data and out_index are valid
out_ready  input  1  sink accepts the current word
out_data  output  DATA_WIDTH  captured register value
out_index  output  ADDR_WIDTH  register index of out_data
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (Reset=0, async): state=IDLE; idx=0; rd_addr=0; out_valid=0; out_data=0; out_index=0; busy=0; done=0.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - rd_addr=0, out_valid=0.
  - start=1 and abort=0: latch idx<=first_addr and end<=last_addr, go READ.
- READ (one cycle):
  - rd_addr=idx.
  - Next edge: out_data<=rd_data, out_index<=idx, go SEND.
- SEND:
  - out_valid=1; out_data and out_index held stable until the handshake.
  - rd_addr stays at idx.
  - On an edge with out_valid & out_ready:
    - idx==end: go DONE.
    - otherwise: idx<=idx+1 (mod NUM_REGS), go READ.
  - out_ready=0 holds SEND indefinitely with no change.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
- Range arithmetic:
  - idx increments modulo NUM_REGS.
  - Words emitted = ((end-first) mod NUM_REGS)+1.
  - first==end: exactly one word.
  - first>end: wraps through index 31 to 0 (e.g. 30..1 gives 30,31,0,1).
  - 0..31: all 32 words.
- Timing:
  - start accepted at edge N: rd_addr=first during cycle N+1; out_valid first rises in cycle N+2.
  - With out_ready held high, throughput is one word per 2 cycles.
- busy: 1 in READ, SEND, DONE.
- start while busy: ignored; range not re-sampled.
- abort=1 in any non-IDLE state:
  - Next edge forces IDLE, out_valid=0, no done pulse.
  - abort has priority over a simultaneous handshake; that word counts as not delivered.
  - start and abort together in IDLE: stay IDLE.
- Data coherency:
  - Data is captured at the READ edge.
  - A register-file write landing on that same edge is not seen; the pre-write value is captured.
  - Writes after capture do not alter out_data.
- Reset mid-dump: immediate return to the reset values above, independent of clock.
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Reset release, regfile r5=0xDEADBEEF, start with first=5 last=5, out_ready=1 -> one word: out_index=5, out_data=0xDEADBEEF, out_valid first high 2 cycles after start; done pulses the cycle after acceptance; busy low afterwards.
- Regfile rN=N*0x11111111 (N=0..31), start 0..31 with out_ready=1 -> 32 words in index order 0..31 with matching data (r0=0); done after word 31; 64 cycles from READ to DONE.
- Range 30..1 -> exactly 4 words with indices 30,31,0,1; no further words.
- out_ready held 0 for 10 cycles in SEND -> out_valid, out_data and out_index stable throughout; rd_addr unchanged; word accepted on the first out_ready=1 edge.
- Dump 0..31, abort asserted during SEND of index 7 with out_ready=1 -> IDLE next cycle, out_valid=0, no done; a new start 3..4 then yields indices 3 and 4 only.
- Register-file write to r2 on the READ edge for index 2 -> old r2 value emitted; start pulsed during SEND -> ignored; Reset asserted mid-dump -> all outputs at reset values asynchronously.
